// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings and constants for the multi-cycle shift sequencer.
// One barrel stage per cycle, stage index counting down from NSTAGE-1.
package shift_pkg;

  localparam int W      = 32;
  localparam int NSTAGE = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Mask selecting the shamt bits strictly below stage k.
  function automatic logic [NSTAGE-1:0] below_mask(input logic [2:0] k);
    logic [NSTAGE-1:0] m;
    m = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (i < int'(k)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Start/ready bus between the execute stage (master) and the shift sequencer (slave).
// ctrl_shift is a start pulse taken only when the unit is idle or done; data_resultRDY
// is a one-cycle pulse with data_result valid, and no backpressure exists on the result.
interface shift_seq_ctrl_if;
  import shift_pkg::*;

  logic           ctrl_shift;
  logic [1:0]     op;
  logic [W-1:0]   data_operandA;
  logic [4:0]     data_shamt;
  logic [W-1:0]   data_result;
  logic           data_resultRDY;
  logic           data_exception;
  logic           busy;

  modport master (
    output ctrl_shift, op, data_operandA, data_shamt,
    input  data_result, data_resultRDY, data_exception, busy
  );

  modport slave (
    input  ctrl_shift, op, data_operandA, data_shamt,
    output data_result, data_resultRDY, data_exception, busy
  );

endinterface

// File: rtl/shift_seq_ctrl_stage.sv
// Single shared barrel stage: shifts acc by 2^stage with the fill the op requires.
// Purely combinational; the sequencer decides whether the shifted value is kept.
module shift_stage
  import shift_pkg::*;
(
  input  logic [W-1:0] acc_i,
  input  logic [2:0]   stage_i,
  input  logic [1:0]   op_i,
  output logic [W-1:0] acc_o
);

  logic [4:0] sh;

  assign sh = 5'd1 << stage_i;

  always_comb begin
    acc_o = acc_i;
    case (op_i)
      OP_SLL:  acc_o = acc_i << sh;
      OP_SRL:  acc_o = acc_i >> sh;
      OP_SRA:  acc_o = $signed(acc_i) >>> sh;
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift-unit sequencer: IDLE -> RUN (one barrel stage per cycle, MSB stage first) -> DONE.
// Shares the multdiv start/ready handshake so stall logic treats both units alike.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  shift_seq_ctrl_if.slave  bus,
  output logic [1:0]       state_dbg_o
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       amt_q, amt_d;
  logic [1:0]       opr_q, opr_d;
  logic [2:0]       stage_q, stage_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] stage_out;
  logic             accept;
  logic             last_stage;

  shift_stage u_stage (
    .acc_i   (acc_q),
    .stage_i (stage_q),
    .op_i    (opr_q),
    .acc_o   (stage_out)
  );

  assign accept     = bus.ctrl_shift && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_stage = (stage_q == 3'd0) ||
                      (EARLY_EXIT && ((amt_q & below_mask(stage_q)) == '0));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    amt_d    = amt_q;
    opr_d    = opr_q;
    stage_d  = stage_q;
    result_d = result_q;

    case (state_q)
      ST_RUN: begin
        acc_d = amt_q[stage_q] ? stage_out : acc_q;
        if (stage_q != 3'd0) stage_d = stage_q - 3'd1;
        if (last_stage) begin
          state_d  = ST_DONE;
          result_d = acc_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Acceptance overrides the DONE->IDLE return so back-to-back requests lose no cycle.
    if (accept) begin
      acc_d   = bus.data_operandA;
      amt_d   = bus.data_shamt;
      opr_d   = bus.op;
      stage_d = 3'd4;
      if (bus.op == OP_ILL) begin
        state_d  = ST_DONE;
        result_d = bus.data_operandA;
      end else begin
        state_d  = ST_RUN;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      amt_q    <= '0;
      opr_q    <= OP_SLL;
      stage_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      amt_q    <= amt_d;
      opr_q    <= opr_d;
      stage_q  <= stage_d;
      result_q <= result_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_resultRDY = (state_q == ST_DONE);
  assign bus.data_exception = (state_q == ST_DONE) && (opr_q == OP_ILL);
  assign bus.busy           = (state_q == ST_RUN);
  assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: one instance per EARLY_EXIT setting, directed cases then
// random requests checked against an arithmetic reference model.
module tb_shift_seq_ctrl;
  import shift_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel   = 1'b0;
  logic        ctrl  = 1'b0;
  logic [1:0]  op_v  = 2'b00;
  logic [31:0] a_v   = '0;
  logic [4:0]  sh_v  = '0;
  logic [1:0]  st0, st1;

  int tests_run    = 0;
  int tests_failed = 0;

  shift_seq_ctrl_if if0 ();
  shift_seq_ctrl_if if1 ();

  assign if0.ctrl_shift    = ctrl && !sel;
  assign if1.ctrl_shift    = ctrl && sel;
  assign if0.op            = op_v;
  assign if1.op            = op_v;
  assign if0.data_operandA = a_v;
  assign if1.data_operandA = a_v;
  assign if0.data_shamt    = sh_v;
  assign if1.data_shamt    = sh_v;

  shift_seq_ctrl #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_dut0 (
    .clock       (clock),
    .reset       (reset),
    .bus         (if0),
    .state_dbg_o (st0)
  );

  shift_seq_ctrl #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_dut1 (
    .clock       (clock),
    .reset       (reset),
    .bus         (if1),
    .state_dbg_o (st1)
  );

  always #5 clock = ~clock;

  logic [31:0] res;
  logic        rdy, exc, busy;
  logic [1:0]  st;
  assign res  = sel ? if1.data_result    : if0.data_result;
  assign rdy  = sel ? if1.data_resultRDY : if0.data_resultRDY;
  assign exc  = sel ? if1.data_exception : if0.data_exception;
  assign busy = sel ? if1.busy           : if0.busy;
  assign st   = sel ? st1                : st0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: result from plain shift arithmetic, latency from the shamt bit pattern.
  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [4:0] sh);
    case (op)
      2'b00:   return a << sh;
      2'b01:   return a >> sh;
      2'b10:   return 32'($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  function automatic int model_cycles(input bit ee, input logic [1:0] op, input logic [4:0] sh);
    int tz;
    if (op == 2'b11) return 1;
    if (!ee) return 6;
    tz = 0;
    while (tz < 5 && sh[tz] == 1'b0) tz++;
    if (tz > 4) tz = 4;
    return (5 - tz) + 1;
  endfunction

  task automatic start(input logic d, input logic [1:0] op, input logic [31:0] a,
                       input logic [4:0] sh);
    sel  = d;
    op_v = op;
    a_v  = a;
    sh_v = sh;
    ctrl = 1'b1;
    @(posedge clock);
    #1 ctrl = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_cyc, input logic [31:0] exp_res,
                             input logic exp_exc, input int pulse_at);
    int cyc = 0;
    bit got = 1'b0;
    while (!got && cyc < 30) begin
      @(negedge clock);
      cyc++;
      if (cyc == pulse_at) begin
        ctrl = 1'b1;
        op_v = OP_SLL;
        a_v  = 32'hDEAD_BEEF;
        sh_v = 5'd3;
      end else begin
        ctrl = 1'b0;
      end
      if (rdy === 1'b1) got = 1'b1;
      else check({tag, " busy_in_run"}, {31'd0, busy}, 32'd1);
    end
    check({tag, " ready_seen"}, {31'd0, got}, 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " result"}, res, exp_res);
    check({tag, " exception"}, {31'd0, exc}, {31'd0, exp_exc});
    check({tag, " busy_at_ready"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_hold(input string tag, input logic [31:0] exp_res);
    @(negedge clock);
    check({tag, " ready_drop"}, {31'd0, rdy}, 32'd0);
    check({tag, " result_hold"}, res, exp_res);
  endtask

  task automatic run_op(input string tag, input logic d, input logic [1:0] op,
                        input logic [31:0] a, input logic [4:0] sh);
    @(negedge clock);
    start(d, op, a, sh);
    wait_result(tag, model_cycles(d, op, sh), model_res(op, a, sh), op == 2'b11, 0);
  endtask

  initial begin
    #12;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      check("reset result", res, 32'd0);
      check("reset ready", {31'd0, rdy}, 32'd0);
      check("reset exception", {31'd0, exc}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset state", {30'd0, st}, {30'd0, ST_IDLE});
    end
    @(negedge clock);
    reset = 1'b0;

    // Fixed latency instance
    @(negedge clock);
    start(1'b0, OP_SRA, 32'hF000_0000, 5'd4);
    wait_result("sra_f0_4", 6, 32'hFF00_0000, 1'b0, 0);
    check_hold("sra_f0_4", 32'hFF00_0000);
    run_op("srl_31", 1'b0, OP_SRL, 32'h8000_0000, 5'd31);
    check("srl_31 value", res, 32'h0000_0001);
    run_op("sll_31", 1'b0, OP_SLL, 32'h0000_0001, 5'd31);
    check("sll_31 value", res, 32'h8000_0000);
    run_op("sra_31", 1'b0, OP_SRA, 32'h8000_0000, 5'd31);
    check("sra_31 value", res, 32'hFFFF_FFFF);

    // Early-exit instance
    @(negedge clock);
    start(1'b1, OP_SLL, 32'h1, 5'd16);
    wait_result("ee_sll16", 2, 32'h0001_0000, 1'b0, 0);
    @(negedge clock);
    start(1'b1, OP_SRL, 32'h80, 5'd1);
    wait_result("ee_shamt1", 6, 32'h40, 1'b0, 0);
    @(negedge clock);
    start(1'b1, OP_SRA, 32'h8765_4321, 5'd0);
    wait_result("ee_shamt0", 2, 32'h8765_4321, 1'b0, 0);

    // Illegal op on both instances
    @(negedge clock);
    start(1'b1, OP_ILL, 32'h1234, 5'd7);
    wait_result("ill_ee1", 1, 32'h1234, 1'b1, 0);
    check_hold("ill_ee1", 32'h1234);
    @(negedge clock);
    start(1'b0, OP_ILL, 32'h1234, 5'd7);
    wait_result("ill_ee0", 1, 32'h1234, 1'b1, 0);

    // Back-to-back: second request taken in the DONE cycle
    @(negedge clock);
    start(1'b1, OP_SLL, 32'h3, 5'd2);
    wait_result("b2b_first", 5, 32'hC, 1'b0, 0);
    start(1'b1, OP_SRL, 32'h100, 5'd8);
    wait_result("b2b_second", 3, 32'h1, 1'b0, 0);

    // Start pulse during RUN must be ignored
    @(negedge clock);
    start(1'b0, OP_SRL, 32'hFFFF_0000, 5'd5);
    wait_result("run_pulse", 6, 32'h07FF_F800, 1'b0, 2);
    check_hold("run_pulse", 32'h07FF_F800);

    // Async reset between edges while stage 2 is pending
    @(negedge clock);
    start(1'b0, OP_SLL, 32'hA5A5_A5A5, 5'd7);
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("midrun_reset result", res, 32'd0);
    check("midrun_reset ready", {31'd0, rdy}, 32'd0);
    check("midrun_reset exception", {31'd0, exc}, 32'd0);
    check("midrun_reset busy", {31'd0, busy}, 32'd0);
    check("midrun_reset state", {30'd0, st}, {30'd0, ST_IDLE});
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    start(1'b0, OP_SRA, 32'hFFFF_FFF0, 5'd4);
    wait_result("post_reset_sra", 6, 32'hFFFF_FFFF, 1'b0, 0);

    // Random requests on either instance
    for (int n = 0; n < 60; n++) begin
      logic        d;
      logic [1:0]  op;
      logic [31:0] a;
      logic [4:0]  sh;
      int          r;
      d  = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      op = (r == 9) ? 2'b11 : 2'(r % 3);
      a  = $urandom;
      sh = 5'($urandom_range(0, 31));
      run_op("random", d, op, a, sh);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
